rca_checker: RTL
================

# rca_checker

Synthesizable response checker that sits at the output end of the ripple-carry adder datapath. It captures each {A, B, Cin} stimulus together with the adder's {Sum, Cout} response and recomputes the expected result. It flags mismatches, counts vectors and errors, and latches the first failing vector for debug. It pairs with any stimulus source, whether bench or on-chip pattern generator, that drives the adder under test.

## Interface
- WIDTH, 4, operand width of the adder under test
- CNT_W, 8, width of vector and error counters

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- clear  input  1  synchronous clear of counters, status and pipeline
- in_valid  input  1  the vector on a/b/cin/sum/cout is valid this cycle
- a  input  WIDTH  operand A applied to the adder
- b  input  WIDTH  operand B applied to the adder
- cin  input  1  carry-in applied to the adder
- sum  input  WIDTH  adder Sum output
- cout  input  1  adder Cout output
- chk_valid  output  1  one-cycle pulse; pass is meaningful
- pass  output  1  checked vector matched the expected result
- status  output  2  0 = IDLE, 1 = PASSING, 2 = FAILED
- vec_count  output  CNT_W  vectors checked, saturating
- err_count  output  CNT_W  mismatches, saturating
- ff_valid  output  1  first-fail record is populated
- ff_a, ff_b  output  WIDTH  operands of the first failing vector
- ff_cin  output  1  carry-in of the first failing vector
- ff_sum  output  WIDTH  observed Sum of the first failing vector
- ff_cout  output  1  observed Cout of the first failing vector

## Operation
- **Stage 1:** when in_valid=1, register a, b, cin, sum and cout, and set s1_valid. Otherwise s1_valid=0.
- **Stage 2:** when s1_valid=1, compute expected {exp_cout, exp_sum} = a + b + cin.
  - The sum is WIDTH+1 bits wide and zero-extends every operand.
  - Compare it against the registered {cout, sum}.
  - Register the result into pass and pulse chk_valid.
- **Counters:**
  - vec_count increments on every chk_valid.
  - err_count increments on every chk_valid with pass=0.
  - Both counters saturate at 2^CNT_W-1 and never wrap.
- **First fail:** on the first mismatch since reset or clear, load ff_a, ff_b, ff_cin, ff_sum and ff_cout, and set ff_valid. Later mismatches leave the record unchanged.
- **Status FSM:**
  - IDLE -> PASSING on the first checked vector with pass=1.
  - IDLE -> FAILED or PASSING -> FAILED on any checked vector with pass=0.
  - FAILED is sticky until rst or clear.
  - Value 3 is unreachable; if it is ever entered, the FSM goes to IDLE on the next clock.
- **clear=1:**
  - On the next edge, zero the counters, ff_* fields, ff_valid, s1_valid, chk_valid and pass, and set status to IDLE.
  - A vector presented with in_valid in the same cycle is dropped.
  - A vector already in stage 1 is discarded.
- **Reset (rst=1):** asynchronously forces every output to 0 and status to IDLE. It discards any vector in flight, even when rst is asserted mid-pipeline.

## Timing
- Vectors are accepted every cycle with no backpressure and no ready signal.
- Latency from in_valid to chk_valid/pass is 2 cycles.
- Back-to-back vectors produce back-to-back chk_valid pulses.
- Counter updates, status transitions and the ff_* load are all visible in the same cycle as the corresponding chk_valid.
- When a pass and the clear are simultaneous (stage-2 check pending and clear=1), clear wins and no counter increments.
- pass holds its last value while chk_valid=0. It returns to 0 only on rst or clear.

## Test plan
- **Correct matches:** after reset, apply these correct adder responses back-to-back:
  - 0000+0000+0 -> sum 0000, cout 0
  - 1111+1111+0 -> sum 1110, cout 1
  - 0011+0101+1 -> sum 1001, cout 0
  - 1000+1000+1 -> sum 0001, cout 1

  Required: 4 chk_valid pulses with pass=1, starting 2 cycles after the first in_valid; vec_count=4; err_count=0; status=PASSING.
- **Injected fault:** apply 1111+1111+0 with sum 1111, cout 1 -> pass=0, err_count=1, status=FAILED. The ff record holds a=1111, b=1111, cin=0, sum=1111, cout=1.
- **Sticky first-fail:** after the fault, apply a second bad vector 0011+0101+1 with sum 1000, then a good vector -> err_count=2, status stays FAILED, ff record unchanged.
- **Saturation:** apply 300 correct vectors with CNT_W=8 -> vec_count=255 and holds; err_count=0.
- **Clear collision:** assert clear in the same cycle as in_valid, with one vector already in stage 1 -> no chk_valid follows; counters=0; status=IDLE; ff_valid=0.
- **Async reset mid-pipeline:** assert rst asynchronously, mid-cycle, while two vectors are in flight -> all outputs go to 0 immediately and no chk_valid pulse appears after rst deasserts.

Source files
------------

// File: rtl/rca_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : rca_checker
//  Purpose  : Response checker for a ripple-carry adder. Captures each
//             {a, b, cin} stimulus with the adder's {sum, cout} response,
//             recomputes the expected result, flags mismatches, keeps
//             saturating vector/error counters and latches the first
//             failing vector for debug.
//  Revision : 1.0  initial release
// ============================================================================
module rca_checker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    output logic             chk_valid,
    output logic             pass,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic             ff_valid,
    output logic [WIDTH-1:0] ff_a,
    output logic [WIDTH-1:0] ff_b,
    output logic             ff_cin,
    output logic [WIDTH-1:0] ff_sum,
    output logic             ff_cout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PASSING = 2'd1,
        ST_FAILED  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    // Stage-1 capture registers
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_cin;
    logic [WIDTH-1:0] r_s1_sum;
    logic             r_s1_cout;

    // Stage-2 result registers
    logic             r_chk_valid;
    logic             r_pass;
    logic [CNT_W-1:0] r_vec_count;
    logic [CNT_W-1:0] r_err_count;
    logic             r_ff_valid;
    logic [WIDTH-1:0] r_ff_a;
    logic [WIDTH-1:0] r_ff_b;
    logic             r_ff_cin;
    logic [WIDTH-1:0] r_ff_sum;
    logic             r_ff_cout;
    state_t           r_state;

    // Expected result: every operand zero-extended to WIDTH+1 bits so the
    // carry out of the top bit lands in the extra MSB.
    logic [WIDTH:0]   w_exp;
    logic             w_match;
    logic             w_fail;

    assign w_exp   = {1'b0, r_s1_a} + {1'b0, r_s1_b} + {{WIDTH{1'b0}}, r_s1_cin};
    assign w_match = (w_exp == {r_s1_cout, r_s1_sum});
    assign w_fail  = r_s1_valid & ~w_match;

    // Stage 1: capture the stimulus/response pair; clear drops both the
    // incoming vector and whatever is already held here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_cin   <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_cout  <= 1'b0;
        end else if (clear) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a    <= a;
                r_s1_b    <= b;
                r_s1_cin  <= cin;
                r_s1_sum  <= sum;
                r_s1_cout <= cout;
            end
        end
    end

    // Stage 2: register the compare result; pass holds between checks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chk_valid <= 1'b0;
            r_pass      <= 1'b0;
        end else if (clear) begin
            r_chk_valid <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            r_chk_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_pass <= w_match;
            end
        end
    end

    // Saturating counters, updated on the same edge that raises chk_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec_count <= '0;
            r_err_count <= '0;
        end else if (clear) begin
            r_vec_count <= '0;
            r_err_count <= '0;
        end else begin
            if (r_s1_valid && (r_vec_count != c_CNT_MAX)) begin
                r_vec_count <= r_vec_count + 1'b1;
            end
            if (w_fail && (r_err_count != c_CNT_MAX)) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    // First-fail record: loads once, then frozen until rst or clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ff_valid <= 1'b0;
            r_ff_a     <= '0;
            r_ff_b     <= '0;
            r_ff_cin   <= 1'b0;
            r_ff_sum   <= '0;
            r_ff_cout  <= 1'b0;
        end else if (clear) begin
            r_ff_valid <= 1'b0;
            r_ff_a     <= '0;
            r_ff_b     <= '0;
            r_ff_cin   <= 1'b0;
            r_ff_sum   <= '0;
            r_ff_cout  <= 1'b0;
        end else if (w_fail && !r_ff_valid) begin
            r_ff_valid <= 1'b1;
            r_ff_a     <= r_s1_a;
            r_ff_b     <= r_s1_b;
            r_ff_cin   <= r_s1_cin;
            r_ff_sum   <= r_s1_sum;
            r_ff_cout  <= r_s1_cout;
        end
    end

    // Status FSM: IDLE until the first check, FAILED is sticky.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (clear) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fail) begin
                        r_state <= ST_FAILED;
                    end else if (r_s1_valid) begin
                        r_state <= ST_PASSING;
                    end
                end
                ST_PASSING: begin
                    if (w_fail) begin
                        r_state <= ST_FAILED;
                    end
                end
                ST_FAILED: begin
                    r_state <= ST_FAILED;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign chk_valid = r_chk_valid;
    assign pass      = r_pass;
    assign status    = r_state;
    assign vec_count = r_vec_count;
    assign err_count = r_err_count;
    assign ff_valid  = r_ff_valid;
    assign ff_a      = r_ff_a;
    assign ff_b      = r_ff_b;
    assign ff_cin    = r_ff_cin;
    assign ff_sum    = r_ff_sum;
    assign ff_cout   = r_ff_cout;

endmodule
`default_nettype wire
